// File: rtl/mult8b_rev_pkg.sv
// mult8b_rev_pkg: garbage layout and direction states shared by the reversible multiplier and its garbage stack
package mult8b_rev_pkg;
  localparam int GARBAGE_W = 63;
  localparam int B0_OFS  = 0;
  localparam int B2_OFS  = 8;
  localparam int B3_OFS  = 16;
  localparam int B4_OFS  = 24;
  localparam int B5_OFS  = 32;
  localparam int B6_OFS  = 40;
  localparam int B7_OFS  = 48;
  localparam int XC0_OFS = 56;
  localparam int B_W     = 8;
  localparam int XC0_W   = 7;
  typedef enum logic [1:0] {FWD, TURN_B, BWD, TURN_F} dir_state_e;
endpackage

// File: rtl/mult8b_garbage_stack_if.sv
// mult8b_garbage_stack_if: direction, push and pop handshake between multiplier side and garbage stack
interface mult8b_garbage_stack_if #(parameter int DEPTH = 16);
  import mult8b_rev_pkg::*;
  logic                   dir_req;
  logic                   dir;
  logic                   turn_busy;
  logic                   f_valid;
  logic                   f_ready;
  logic [GARBAGE_W-1:0]   f_garbage;
  logic                   r_pop;
  logic                   r_valid;
  logic [GARBAGE_W-1:0]   r_garbage;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   err_underflow;
  logic                   err_clr;
  modport master (
    output dir_req, f_valid, f_garbage, r_pop, err_clr,
    input  dir, turn_busy, f_ready, r_valid, r_garbage, count, full, empty, err_underflow
  );
  modport slave (
    input  dir_req, f_valid, f_garbage, r_pop, err_clr,
    output dir, turn_busy, f_ready, r_valid, r_garbage, count, full, empty, err_underflow
  );
endinterface

// File: rtl/garbage_lifo.sv
// garbage_lifo: DEPTH-entry LIFO of garbage words with stack pointer, count and full/empty flags
module garbage_lifo
  import mult8b_rev_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [GARBAGE_W-1:0]   wdata,
  output logic [GARBAGE_W-1:0]   rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  logic [GARBAGE_W-1:0] mem [DEPTH];
  logic [AW:0]          sp;
  logic [AW-1:0]        rd_idx;
  assign rd_idx = sp[AW-1:0] - 1'b1;
  assign rdata  = mem[rd_idx];
  assign count  = sp;
  assign full   = sp == (AW+1)'(DEPTH);
  assign empty  = sp == '0;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) sp <= '0;
    else sp <= push ? sp + 1'b1 : pop ? sp - 1'b1 : sp;
  // storage is not reset: only sp defines which entries are live
  always_ff @(posedge clk)
    if (push) mem[sp[AW-1:0]] <= wdata;
endmodule

// File: rtl/mult8b_garbage_stack.sv
// mult8b_garbage_stack: garbage LIFO plus direction sequencer for the reversible 8-bit multiplier
module mult8b_garbage_stack
  import mult8b_rev_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int TURN_CYCLES = 1
) (
  input logic                   clk,
  input logic                   rst_n,
  mult8b_garbage_stack_if.slave bus
);
  localparam int TW = TURN_CYCLES > 1 ? $clog2(TURN_CYCLES) : 1;
  localparam logic [TW-1:0] TLAST = TW'(TURN_CYCLES - 1);
  dir_state_e           state;
  logic [TW-1:0]        tcnt;
  logic                 push;
  logic                 pop;
  logic                 full;
  logic                 empty;
  logic [GARBAGE_W-1:0] top_data;
  assign bus.full    = full;
  assign bus.empty   = empty;
  assign bus.f_ready = state == FWD && !full;
  assign push        = bus.f_valid && bus.f_ready;
  assign pop         = state == BWD && bus.r_pop && !empty;
  garbage_lifo #(.DEPTH(DEPTH)) u_lifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (bus.f_garbage),
    .rdata (top_data),
    .count (bus.count),
    .full  (full),
    .empty (empty)
  );
  // dir flips on entry to a turn state so the bus settles before any transfer
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state         <= FWD;
      bus.dir       <= 1'b0;
      bus.turn_busy <= 1'b0;
      tcnt          <= '0;
    end else
      case (state)
        FWD:
          if (bus.dir_req) begin
            state         <= TURN_B;
            bus.dir       <= 1'b1;
            bus.turn_busy <= 1'b1;
            tcnt          <= '0;
          end
        TURN_B:
          if (tcnt == TLAST) begin
            state         <= BWD;
            bus.turn_busy <= 1'b0;
          end else tcnt <= tcnt + 1'b1;
        BWD:
          if (!bus.dir_req) begin
            state         <= TURN_F;
            bus.dir       <= 1'b0;
            bus.turn_busy <= 1'b1;
            tcnt          <= '0;
          end
        TURN_F:
          if (tcnt == TLAST) begin
            state         <= FWD;
            bus.turn_busy <= 1'b0;
          end else tcnt <= tcnt + 1'b1;
      endcase
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      bus.r_valid       <= 1'b0;
      bus.r_garbage     <= '0;
      bus.err_underflow <= 1'b0;
    end else begin
      bus.r_valid       <= pop;
      bus.r_garbage     <= pop ? top_data : bus.r_garbage;
      bus.err_underflow <= bus.err_clr ? 1'b0 :
                           (state == BWD && bus.r_pop && empty) ? 1'b1 : bus.err_underflow;
    end
endmodule

// File: tb/tb_mult8b_garbage_stack.sv
// tb_mult8b_garbage_stack: directed table and sequence checks of the garbage stack with a 3-cycle turnaround
module tb_mult8b_garbage_stack;
  import mult8b_rev_pkg::*;
  localparam int DEPTH = 16;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   errors = 0;
  int   checks = 0;
  always #5 clk = ~clk;
  mult8b_garbage_stack_if #(.DEPTH(DEPTH)) bus ();
  mult8b_garbage_stack #(.DEPTH(DEPTH), .TURN_CYCLES(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );
  typedef struct {
    logic        dreq, fv, rp;
    logic [62:0] d;
    logic        e_dir, e_busy, e_rv, e_empty, e_frdy;
    int          e_cnt;
    logic [62:0] e_rg;
  } vec_t;
  vec_t tv[12];
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic wait_idle(input string n);
    int k = 0;
    while (bus.turn_busy && k < 10) begin
      step();
      k++;
    end
    chk({n, " turn done"}, 64'(bus.turn_busy), 64'd0);
  endtask
  initial begin
    logic [62:0] d99 = 63'd99;
    tv[0]  = '{1'b0, 1'b1, 1'b0, 63'h1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1, 63'h0};
    tv[1]  = '{1'b0, 1'b1, 1'b0, 63'h2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2, 63'h0};
    tv[2]  = '{1'b0, 1'b1, 1'b0, 63'h3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 3, 63'h0};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 63'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 63'h0};
    tv[4]  = '{1'b1, 1'b1, 1'b1, d99,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 63'h0};
    tv[5]  = '{1'b1, 1'b1, 1'b1, d99,   1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3, 63'h0};
    tv[6]  = '{1'b1, 1'b1, 1'b1, d99,   1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3, 63'h0};
    tv[7]  = '{1'b1, 1'b0, 1'b1, 63'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2, 63'h3};
    tv[8]  = '{1'b1, 1'b0, 1'b1, 63'h0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1, 63'h2};
    tv[9]  = '{1'b1, 1'b0, 1'b0, 63'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1, 63'h2};
    tv[10] = '{1'b1, 1'b0, 1'b1, 63'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, 63'h1};
    tv[11] = '{1'b1, 1'b0, 1'b0, 63'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 0, 63'h1};
    bus.dir_req = 1'b0; bus.f_valid = 1'b0; bus.f_garbage = '0; bus.r_pop = 1'b0; bus.err_clr = 1'b0;
    #1;
    chk("rst dir", 64'(bus.dir), 64'd0);
    chk("rst busy", 64'(bus.turn_busy), 64'd0);
    chk("rst count", 64'(bus.count), 64'd0);
    chk("rst empty", 64'(bus.empty), 64'd1);
    chk("rst full", 64'(bus.full), 64'd0);
    chk("rst r_valid", 64'(bus.r_valid), 64'd0);
    chk("rst r_garbage", 64'(bus.r_garbage), 64'd0);
    chk("rst err", 64'(bus.err_underflow), 64'd0);
    step();
    step();
    rst_n = 1'b1;
    chk("post-rst f_ready", 64'(bus.f_ready), 64'd1);
    for (int i = 0; i < 12; i++) begin
      bus.dir_req = tv[i].dreq; bus.f_valid = tv[i].fv; bus.r_pop = tv[i].rp; bus.f_garbage = tv[i].d;
      step();
      chk($sformatf("row%0d dir", i), 64'(bus.dir), 64'(tv[i].e_dir));
      chk($sformatf("row%0d busy", i), 64'(bus.turn_busy), 64'(tv[i].e_busy));
      chk($sformatf("row%0d r_valid", i), 64'(bus.r_valid), 64'(tv[i].e_rv));
      chk($sformatf("row%0d empty", i), 64'(bus.empty), 64'(tv[i].e_empty));
      chk($sformatf("row%0d f_ready", i), 64'(bus.f_ready), 64'(tv[i].e_frdy));
      chk($sformatf("row%0d count", i), 64'(bus.count), 64'(tv[i].e_cnt));
      chk($sformatf("row%0d r_garbage", i), 64'(bus.r_garbage), 64'(tv[i].e_rg));
    end
    bus.f_valid = 1'b0; bus.r_pop = 1'b1;
    step();
    chk("uf r_valid", 64'(bus.r_valid), 64'd0);
    chk("uf err set", 64'(bus.err_underflow), 64'd1);
    chk("uf count", 64'(bus.count), 64'd0);
    bus.r_pop = 1'b0;
    step();
    chk("uf sticky", 64'(bus.err_underflow), 64'd1);
    bus.err_clr = 1'b1;
    step();
    chk("uf cleared", 64'(bus.err_underflow), 64'd0);
    bus.err_clr = 1'b0; bus.r_pop = 1'b1;
    step();
    chk("uf reset", 64'(bus.err_underflow), 64'd1);
    bus.err_clr = 1'b1;
    step();
    chk("uf clr priority", 64'(bus.err_underflow), 64'd0);
    bus.err_clr = 1'b0; bus.r_pop = 1'b0; bus.dir_req = 1'b0;
    step();
    chk("tf dir", 64'(bus.dir), 64'd0);
    chk("tf f_ready", 64'(bus.f_ready), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("tf busy%0d", i), 64'(bus.turn_busy), 64'(i < 2));
    end
    chk("fwd f_ready", 64'(bus.f_ready), 64'd1);
    bus.dir_req = 1'b1;
    step();
    chk("tgl dir", 64'(bus.dir), 64'd1);
    chk("tgl busy0", 64'(bus.turn_busy), 64'd1);
    bus.dir_req = 1'b0; bus.f_valid = 1'b1; bus.f_garbage = 63'd77;
    step();
    chk("tgl busy1", 64'(bus.turn_busy), 64'd1);
    step();
    chk("tgl busy2", 64'(bus.turn_busy), 64'd1);
    step();
    chk("tgl bwd busy", 64'(bus.turn_busy), 64'd0);
    chk("tgl bwd dir", 64'(bus.dir), 64'd1);
    step();
    chk("tgl turn_f dir", 64'(bus.dir), 64'd0);
    chk("tgl turn_f busy", 64'(bus.turn_busy), 64'd1);
    chk("tgl no push", 64'(bus.count), 64'd0);
    bus.f_valid = 1'b0;
    wait_idle("tgl");
    chk("tgl f_ready", 64'(bus.f_ready), 64'd1);
    bus.r_pop = 1'b1;
    step();
    chk("fwd pop r_valid", 64'(bus.r_valid), 64'd0);
    chk("fwd pop err", 64'(bus.err_underflow), 64'd0);
    bus.r_pop = 1'b0; bus.f_valid = 1'b1;
    for (int k = 0; k < DEPTH + 2; k++) begin
      bus.f_garbage = 63'(100 + k);
      step();
      chk($sformatf("full%0d count", k), 64'(bus.count), 64'(k < DEPTH ? k + 1 : DEPTH));
      chk($sformatf("full%0d full", k), 64'(bus.full), 64'(k >= DEPTH - 1));
      chk($sformatf("full%0d f_ready", k), 64'(bus.f_ready), 64'(k < DEPTH - 1));
    end
    bus.f_valid = 1'b0; bus.dir_req = 1'b1;
    step();
    wait_idle("full");
    bus.r_pop = 1'b1;
    step();
    chk("full pop1 r_valid", 64'(bus.r_valid), 64'd1);
    chk("full pop1 data", 64'(bus.r_garbage), 64'd115);
    step();
    chk("full pop2 data", 64'(bus.r_garbage), 64'd114);
    chk("full pop2 count", 64'(bus.count), 64'd14);
    bus.r_pop = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("arst dir", 64'(bus.dir), 64'd0);
    chk("arst count", 64'(bus.count), 64'd0);
    chk("arst r_garbage", 64'(bus.r_garbage), 64'd0);
    chk("arst r_valid", 64'(bus.r_valid), 64'd0);
    chk("arst empty", 64'(bus.empty), 64'd1);
    bus.dir_req = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    chk("arst f_ready", 64'(bus.f_ready), 64'd1);
    chk("arst count hold", 64'(bus.count), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
